// File: rtl/cont2_seq_checker_pkg.sv
// Shared types and phase helpers for the type-2 bounce counter checker.
// A phase p maps onto the bounce sequence 0..MAX,MAX..0; the upper half of the phase range counts down.
package cont2_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACQ     = 2'd1,
    CONFIRM = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  localparam int ERR_CNT_W = 8;
  // Widest phase the helpers accept (WIDTH up to 16).
  localparam int PH_MAX_W  = 17;

  function automatic logic [PH_MAX_W-1:0] phase_to_val(input logic [PH_MAX_W-1:0] p,
                                                       input int width);
    logic [PH_MAX_W-1:0] half;
    logic [PH_MAX_W-1:0] last;
    half = {{(PH_MAX_W-1){1'b0}}, 1'b1} << width;
    last = (half << 1) - 1'b1;
    return (p < half) ? p : (last - p);
  endfunction

  function automatic logic phase_dir(input logic [PH_MAX_W-1:0] p, input int width);
    logic [PH_MAX_W-1:0] t;
    t = p >> width;
    return t[0];
  endfunction

endpackage

// File: rtl/cont2_seq_checker_phase_track.sv
// Phase register for the bounce checker: loads an acquired phase or advances by one,
// and registers the expected next value and the direction alongside it.
module cont2_phase_track
  import cont2_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH:0]   load_phase,
  input  logic             advance,
  input  logic             clear_exp,
  output logic [WIDTH-1:0] exp_val,
  output logic             dir_out
);

  logic [WIDTH:0] phase;
  logic [WIDTH:0] next_phase;

  function automatic logic [WIDTH-1:0] val_after(input logic [WIDTH:0] p);
    logic [WIDTH:0] n;
    n = p + 1'b1;
    return WIDTH'(phase_to_val(PH_MAX_W'(n), WIDTH));
  endfunction

  always_comb begin
    next_phase = phase;
    if (load)
      next_phase = load_phase;
    else if (advance)
      next_phase = phase + 1'b1;
  end

  // Wrap from the last phase back to 0 comes for free from the WIDTH+1 bit add.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase   <= '0;
      exp_val <= '0;
      dir_out <= 1'b0;
    end else if (load || advance) begin
      phase   <= next_phase;
      exp_val <= val_after(next_phase);
      dir_out <= phase_dir(PH_MAX_W'(next_phase), WIDTH);
    end else if (clear_exp) begin
      exp_val <= '0;
    end
  end

endmodule

// File: rtl/cont2_seq_checker.sv
// Receive-side checker for the type-2 bounce counter: acquires phase, locks, flags violations.
// Define CONT2_CHK_FLYWHEEL_EN to ride through a single bad sample while locked.
module cont2_seq_checker
  import cont2_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     sa_in,
  input  logic                 valid_in,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 dir_out,
  output logic [WIDTH-1:0]     exp_val
);

  localparam logic [WIDTH-1:0] MAX_V = '1;
  localparam logic [WIDTH:0]   TOP_PHASE = {1'b1, {WIDTH{1'b0}}};

  state_t           state;
  state_t           nxt_state;
  logic [WIDTH-1:0] first;
  logic [WIDTH-1:0] nxt_first;
  logic [3:0]       match_cnt;
  logic [3:0]       nxt_cnt;
  logic             load;
  logic             advance;
  logic             clear_exp;
  logic             viol;
  logic             acq_hit;
  logic [WIDTH:0]   acq_phase;
  logic             match;
`ifdef CONT2_CHK_FLYWHEEL_EN
  logic             miss;
  logic             nxt_miss;
`endif

  assign match = (sa_in == exp_val);

  // Two successive samples pin the phase uniquely, including both turnaround repeats.
  always_comb begin
    acq_hit   = 1'b0;
    acq_phase = '0;
    if (first != MAX_V && sa_in == first + 1'b1) begin
      acq_hit   = 1'b1;
      acq_phase = {1'b0, sa_in};
    end else if (first != '0 && sa_in == first - 1'b1) begin
      acq_hit   = 1'b1;
      acq_phase = {1'b1, ~sa_in};
    end else if (sa_in == first && first == MAX_V) begin
      acq_hit   = 1'b1;
      acq_phase = TOP_PHASE;
    end else if (sa_in == first && first == '0) begin
      acq_hit   = 1'b1;
      acq_phase = '0;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_first = first;
    nxt_cnt   = match_cnt;
    load      = 1'b0;
    advance   = 1'b0;
    clear_exp = 1'b0;
    viol      = 1'b0;
`ifdef CONT2_CHK_FLYWHEEL_EN
    nxt_miss  = miss;
`endif
    if (valid_in) begin
      case (state)
        HUNT: begin
          nxt_first = sa_in;
          nxt_state = ACQ;
        end
        ACQ: begin
          if (acq_hit) begin
            load      = 1'b1;
            nxt_cnt   = 4'd1;
            nxt_state = CONFIRM;
          end else begin
            nxt_first = sa_in;
          end
        end
        CONFIRM: begin
          if (match) begin
            advance = 1'b1;
            nxt_cnt = match_cnt + 4'd1;
            if (nxt_cnt == 4'(LOCK_CNT))
              nxt_state = LOCKED;
          end else begin
            nxt_first = sa_in;
            nxt_cnt   = '0;
            clear_exp = 1'b1;
            nxt_state = ACQ;
          end
        end
        LOCKED: begin
          if (match) begin
            advance = 1'b1;
`ifdef CONT2_CHK_FLYWHEEL_EN
            nxt_miss = 1'b0;
`endif
          end else begin
            viol = 1'b1;
`ifdef CONT2_CHK_FLYWHEEL_EN
            if (!miss) begin
              nxt_miss = 1'b1;
              advance  = 1'b1;
            end else begin
              nxt_miss  = 1'b0;
              nxt_first = sa_in;
              nxt_cnt   = '0;
              clear_exp = 1'b1;
              nxt_state = ACQ;
            end
`else
            nxt_first = sa_in;
            nxt_cnt   = '0;
            clear_exp = 1'b1;
            nxt_state = ACQ;
`endif
          end
        end
        default: nxt_state = HUNT;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= HUNT;
      first     <= '0;
      match_cnt <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= nxt_state;
      first     <= nxt_first;
      match_cnt <= nxt_cnt;
      locked    <= (nxt_state == LOCKED);
      err       <= viol;
      if (viol && err_count != '1)
        err_count <= err_count + 1'b1;
    end
  end

`ifdef CONT2_CHK_FLYWHEEL_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      miss <= 1'b0;
    else
      miss <= nxt_miss;
  end
`endif

  cont2_phase_track #(
    .WIDTH(WIDTH)
  ) u_phase (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_phase (acq_phase),
    .advance    (advance),
    .clear_exp  (clear_exp),
    .exp_val    (exp_val),
    .dir_out    (dir_out)
  );

endmodule
